// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A single-port arbiter still needs a one-bit index.
  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward,
// wrapping modulo NUM_PORTS.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_BITS  = idx_bits(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_BITS-1:0]  rr_ptr,
  output logic                 found,
  output logic [IDX_BITS-1:0]  winner
);

  localparam logic [IDX_BITS:0] PORT_COUNT = (IDX_BITS+1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0] rotated;
  logic [IDX_BITS-1:0]  offset;
  logic [IDX_BITS:0]    sum;

  always_comb begin
    // Shifting the doubled vector puts request[rr_ptr] at bit 0 with wrap-around.
    rotated = NUM_PORTS'({request, request} >> rr_ptr);
    found   = 1'b0;
    offset  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IDX_BITS'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= PORT_COUNT) begin
      sum = sum - PORT_COUNT;
    end
    winner = sum[IDX_BITS-1:0];
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink among NUM_PORTS sources.
// Define AXIS_ARB_SRC_ID_EN to add a maxis_tid output carrying the granted source index.
module axis_rr_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_BITS = 32,
  parameter int IDX_BITS  = idx_bits(NUM_PORTS)
) (
  input  logic                           clock,
  input  logic                           aresetn,
  input  logic [NUM_PORTS*DATA_BITS-1:0] saxis_tdata,
  input  logic [NUM_PORTS-1:0]           saxis_tvalid,
  input  logic [NUM_PORTS-1:0]           saxis_tlast,
  output logic [NUM_PORTS-1:0]           saxis_tready,
  output logic [DATA_BITS-1:0]           maxis_tdata,
  output logic                           maxis_tvalid,
  output logic                           maxis_tlast,
  input  logic                           maxis_tready,
`ifdef AXIS_ARB_SRC_ID_EN
  output logic [IDX_BITS-1:0]            maxis_tid,
`endif
  output logic                           grant_active,
  output logic [IDX_BITS-1:0]            grant_index
);

  localparam logic [IDX_BITS:0] PORT_COUNT = (IDX_BITS+1)'(NUM_PORTS);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [IDX_BITS-1:0] grant_next;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] rr_next;
  logic [IDX_BITS:0]   grant_inc;
  logic                pick_found;
  logic [IDX_BITS-1:0] pick_winner;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_BITS  (IDX_BITS)
  ) u_picker (
    .request (saxis_tvalid),
    .rr_ptr  (rr_ptr),
    .found   (pick_found),
    .winner  (pick_winner)
  );

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ARB_IDLE;
      grant_index <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_next;
      grant_index <= grant_next;
      rr_ptr      <= rr_next;
    end
  end

  // Ready is steered from state and grant only, never from any source's tvalid.
  always_comb begin
    state_next   = state;
    grant_next   = grant_index;
    rr_next      = rr_ptr;
    grant_inc    = {1'b0, grant_index} + {{IDX_BITS{1'b0}}, 1'b1};
    maxis_tdata  = '0;
    maxis_tvalid = 1'b0;
    maxis_tlast  = 1'b0;
    saxis_tready = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_next = ARB_LOCKED;
          grant_next = pick_winner;
        end
      end
      ARB_LOCKED: begin
        maxis_tdata               = saxis_tdata[grant_index*DATA_BITS +: DATA_BITS];
        maxis_tvalid              = saxis_tvalid[grant_index];
        maxis_tlast               = saxis_tlast[grant_index];
        saxis_tready[grant_index] = maxis_tready;
        if (maxis_tvalid && maxis_tready && maxis_tlast) begin
          state_next = ARB_IDLE;
          rr_next    = (grant_inc >= PORT_COUNT) ? '0 : grant_inc[IDX_BITS-1:0];
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign grant_active = (state == ARB_LOCKED);

`ifdef AXIS_ARB_SRC_ID_EN
  assign maxis_tid = grant_active ? grant_index : '0;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Self-checking bench for axis_rr_packet_arbiter: per-source BFMs, a scoreboard of expected
// beats per source, a round-robin reference model and directed lock/reset scenarios.
module tb_axis_rr_packet_arbiter;

  localparam int NUM_PORTS = 4;
  localparam int DATA_BITS = 32;
  localparam int IDX_BITS  = 2;

  typedef struct packed {
    logic [3:0]  port;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic                           clock;
  logic                           aresetn;
  logic [NUM_PORTS*DATA_BITS-1:0] saxis_tdata;
  logic [NUM_PORTS-1:0]           saxis_tvalid;
  logic [NUM_PORTS-1:0]           saxis_tlast;
  logic [NUM_PORTS-1:0]           saxis_tready;
  logic [DATA_BITS-1:0]           maxis_tdata;
  logic                           maxis_tvalid;
  logic                           maxis_tlast;
  logic                           maxis_tready;
  logic                           grant_active;
  logic [IDX_BITS-1:0]            grant_index;
`ifdef AXIS_ARB_SRC_ID_EN
  logic [IDX_BITS-1:0]            maxis_tid;
`endif

  int checks   = 0;
  int failures = 0;

  beat_t src_q[NUM_PORTS][$];
  beat_t exp_q[NUM_PORTS][$];
  int    grant_log[$];

  logic [NUM_PORTS-1:0] hold;
  logic                 bp_en;
  logic                 gap_check_en;
  logic                 gap_have_end;
  int                   stall;

  int                   exp_ptr;
  int                   cyc;
  int                   last_end;
  logic                 prev_active;
  logic                 pend_ok;
  logic                 in_pkt;
  logic [NUM_PORTS-1:0] pend;
  int                   wait_cnt[NUM_PORTS];

  axis_rr_packet_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .DATA_BITS (DATA_BITS),
    .IDX_BITS  (IDX_BITS)
  ) dut (
    .clock        (clock),
    .aresetn      (aresetn),
    .saxis_tdata  (saxis_tdata),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tlast  (saxis_tlast),
    .saxis_tready (saxis_tready),
    .maxis_tdata  (maxis_tdata),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tlast  (maxis_tlast),
    .maxis_tready (maxis_tready),
`ifdef AXIS_ARB_SRC_ID_EN
    .maxis_tid    (maxis_tid),
`endif
    .grant_active (grant_active),
    .grant_index  (grant_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input int nbeats, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.port = 4'(port);
      b.data = base + 32'(k);
      b.last = (k == nbeats - 1);
      src_q[port].push_back(b);
      exp_q[port].push_back(b);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_PORTS-1:0] req, input int ptr);
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = (ptr + k) % NUM_PORTS;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_PORTS; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < NUM_PORTS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    grant_log.delete();
    hold = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain", pending(), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clock);
    #2 aresetn = 1'b0;
    clear_queues();
    repeat (cycles) @(negedge clock);
    #2 aresetn = 1'b1;
  endtask

  // Per-negedge observation: grant decisions against the reference model, scoreboard on beats.
  task automatic monitor_cycle();
    beat_t b;
    int    g;
    int    w;
    cyc++;
    g = int'(grant_index);
    if (!prev_active && pend_ok) checkOutput("grant_after_request", grant_active, 1);
    if (grant_active && !prev_active) begin
      grant_log.push_back(g);
      w = rr_pick(pend, exp_ptr);
      checkOutput("rr_winner", g, w);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pend[i]) begin
          if (i == g) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            checkOutput("wait_bound", wait_cnt[i] > NUM_PORTS - 1, 0);
          end
        end
      end
    end
    if (!grant_active) begin
      checkOutput("idle_tvalid", maxis_tvalid, 0);
      checkOutput("idle_tready", saxis_tready, 0);
      pend    = saxis_tvalid;
      pend_ok = |saxis_tvalid;
    end else begin
      pend_ok = 1'b0;
      checkOutput("ready_route", saxis_tready, maxis_tready ? (4'b0001 << g) : 4'b0000);
      if (maxis_tvalid && maxis_tready) begin
        checkOutput("beat_expected", exp_q[g].size() != 0, 1);
        if (exp_q[g].size() != 0) begin
          b = exp_q[g].pop_front();
          checkOutput("tdata", maxis_tdata, b.data);
          checkOutput("tlast", maxis_tlast, b.last);
`ifdef AXIS_ARB_SRC_ID_EN
          checkOutput("tid", maxis_tid, b.port);
`endif
          if (!in_pkt && gap_check_en && gap_have_end) checkOutput("bubble_gap", cyc - last_end, 2);
          if (b.last) begin
            exp_ptr      = (g + 1) % NUM_PORTS;
            last_end     = cyc;
            gap_have_end = 1'b1;
            in_pkt       = 1'b0;
          end else begin
            in_pkt = 1'b1;
          end
        end
      end
    end
    prev_active = grant_active;
  endtask

  // Source BFMs and downstream backpressure; inputs change only 1 time unit after posedge.
  initial begin : bfm
    logic [NUM_PORTS-1:0] accepted;
    saxis_tvalid = '0;
    saxis_tdata  = '0;
    saxis_tlast  = '0;
    maxis_tready = 1'b0;
    accepted     = '0;
    stall        = 0;
    forever begin
      @(negedge clock);
      if (!aresetn) begin
        accepted     = '0;
        exp_ptr      = 0;
        prev_active  = 1'b0;
        pend_ok      = 1'b0;
        in_pkt       = 1'b0;
        gap_have_end = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] = 0;
      end else begin
        accepted = saxis_tvalid & saxis_tready;
        if (maxis_tvalid && maxis_tready) stall = bp_en ? int'($urandom_range(0, 2)) : 0;
        monitor_cycle();
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (aresetn && accepted[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !hold[i]) begin
          saxis_tvalid[i]                          = 1'b1;
          saxis_tdata[i*DATA_BITS +: DATA_BITS]    = src_q[i][0].data;
          saxis_tlast[i]                           = src_q[i][0].last;
        end else begin
          saxis_tvalid[i]                          = 1'b0;
          saxis_tdata[i*DATA_BITS +: DATA_BITS]    = '0;
          saxis_tlast[i]                           = 1'b0;
        end
      end
      if (!bp_en) maxis_tready = 1'b1;
      else if (stall > 0) begin
        maxis_tready = 1'b0;
        stall--;
      end else maxis_tready = 1'b1;
    end
  end

  initial begin : stimulus
    int n;
    int port;
    int nb;
    aresetn      = 1'b0;
    hold         = '0;
    bp_en        = 1'b0;
    gap_check_en = 1'b0;
    gap_have_end = 1'b0;
    cyc          = 0;
    last_end     = 0;

    // Reset values held throughout a 4-cycle reset
    repeat (4) begin
      @(negedge clock);
      checkOutput("rst_tvalid", maxis_tvalid, 0);
      checkOutput("rst_tready", saxis_tready, 0);
      checkOutput("rst_active", grant_active, 0);
      checkOutput("rst_index", grant_index, 0);
    end
    #2 aresetn = 1'b1;

    // Single 3-beat packet from source 2
    @(negedge clock);
    grant_log.delete();
    applyStimulus(2, 3, 32'hA0);
    @(negedge clock);
    checkOutput("t2_idle_active", grant_active, 0);
    @(negedge clock);
    checkOutput("t2_grant_active", grant_active, 1);
    checkOutput("t2_grant_index", grant_index, 2);
    checkOutput("t2_first_beat", maxis_tdata, 32'hA0);
    repeat (3) @(negedge clock);
    checkOutput("t2_idle_after_last", grant_active, 0);
    wait_drain(20);

    // Round-robin rotation with all sources requesting 2-beat packets
    applyReset(2);
    gap_check_en = 1'b1;
    @(negedge clock);
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NUM_PORTS; s++)
        applyStimulus(s, 2, {4'(s), 16'(p), 12'h000});
    wait_drain(200);
    gap_check_en = 1'b0;
    checkOutput("t3_grant_count", grant_log.size(), 12);
    for (int k = 0; k < grant_log.size() && k < 12; k++) checkOutput("t3_grant_order", grant_log[k], k % NUM_PORTS);

    // Lock held while source 1 stalls mid-packet and source 3 requests
    @(negedge clock);
    grant_log.delete();
    applyStimulus(1, 3, {4'd1, 16'h0400, 12'h000});
    for (n = 0; n < 20; n++) begin
      @(negedge clock);
      if (grant_active && saxis_tvalid[1] && saxis_tready[1]) break;
    end
    checkOutput("t4_src1_started", n < 20, 1);
    hold[1] = 1'b1;
    applyStimulus(3, 2, {4'd3, 16'h0401, 12'h000});
    repeat (5) begin
      @(negedge clock);
      checkOutput("t4_lock_active", grant_active, 1);
      checkOutput("t4_lock_index", grant_index, 1);
      checkOutput("t4_lock_tvalid", maxis_tvalid, 0);
      checkOutput("t4_src3_tready", saxis_tready[3], 0);
    end
    hold[1] = 1'b0;
    wait_drain(50);
    checkOutput("t4_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      checkOutput("t4_first_grant", grant_log[0], 1);
      checkOutput("t4_second_grant", grant_log[1], 3);
    end

    // Single-beat packet moves the pointer, then reset lands mid-packet
    @(negedge clock);
    grant_log.delete();
    applyStimulus(1, 1, {4'd1, 16'h0500, 12'h000});
    wait_drain(20);
    applyStimulus(2, 4, {4'd2, 16'h0501, 12'h000});
    for (n = 0; n < 20; n++) begin
      @(negedge clock);
      if (maxis_tvalid && maxis_tready && maxis_tdata == {4'd2, 16'h0501, 12'h001}) break;
    end
    checkOutput("t5_beat2_seen", n < 20, 1);
    #2 aresetn = 1'b0;
    clear_queues();
    #1;
    checkOutput("t5_rst_tvalid", maxis_tvalid, 0);
    checkOutput("t5_rst_tready", saxis_tready, 0);
    checkOutput("t5_rst_active", grant_active, 0);
    checkOutput("t5_rst_index", grant_index, 0);
    repeat (2) @(negedge clock);
    #2 aresetn = 1'b1;
    applyStimulus(3, 2, {4'd3, 16'h0502, 12'h000});
    applyStimulus(1, 2, {4'd1, 16'h0503, 12'h000});
    wait_drain(50);
    checkOutput("t5_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      checkOutput("t5_first_grant", grant_log[0], 1);
      checkOutput("t5_second_grant", grant_log[1], 3);
    end

    // Random soak with downstream backpressure
    bp_en = 1'b1;
    @(negedge clock);
    for (int p = 0; p < 1000; p++) begin
      port = int'($urandom_range(0, NUM_PORTS - 1));
      nb   = int'($urandom_range(1, 8));
      applyStimulus(port, nb, {4'(port), 16'(p), 12'h000});
    end
    wait_drain(40000);
    bp_en = 1'b0;

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
